// File: rtl/vliw_fetch_stage.sv
// vliw_fetch_stage: VLIW instruction fetch. Generates the PC, resolves the
// redirect priority, buffers bundles in a prefetch queue and drives the
// IF/ID output register through a valid/ready handshake.
module vliw_fetch_stage #(
    parameter int                SLOT_W     = 16,
    parameter int                NUM_SLOTS  = 2,
    parameter int                PC_W       = 32,
    parameter int                FQ_DEPTH   = 4,
    parameter logic [PC_W-1:0]   RESET_PC   = '0,
    parameter logic [PC_W-1:0]   EXC_VECTOR = PC_W'(32'h80)
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic                          imem_req,
    output logic [PC_W-1:0]               imem_addr,
    input  logic [NUM_SLOTS*SLOT_W-1:0]   imem_rdata,
    input  logic                          branch_taken,
    input  logic [PC_W-1:0]               branch_target,
    input  logic                          jump,
    input  logic [PC_W-1:0]               jump_target,
    input  logic                          exception,
    input  logic                          id_ready,
    output logic                          p1_valid,
    output logic [NUM_SLOTS*SLOT_W-1:0]   p1_bundle,
    output logic [PC_W-1:0]               p1_pc,
    output logic [$clog2(FQ_DEPTH):0]     fq_count
);

    localparam int              BW      = NUM_SLOTS * SLOT_W;
    localparam int              AW      = $clog2(FQ_DEPTH);
    localparam int              CW      = AW + 1;
    localparam logic [PC_W-1:0] PC_STEP = PC_W'(BW / 8);

    logic [PC_W-1:0] r_pc;
    logic            r_inflight;
    logic [PC_W-1:0] r_req_addr;

    logic [BW-1:0]   r_fq_data [FQ_DEPTH];
    logic [PC_W-1:0] r_fq_pc   [FQ_DEPTH];
    logic [AW-1:0]   r_head;
    logic [AW-1:0]   r_tail;
    logic [CW-1:0]   r_count;

    logic            r_p1_valid;
    logic [BW-1:0]   r_p1_bundle;
    logic [PC_W-1:0] r_p1_pc;

    logic            w_redirect;
    logic [PC_W-1:0] w_target;
    logic [CW-1:0]   w_occ;
    logic            w_req;
    logic            w_resp;
    logic            w_load;
    logic            w_pop;
    logic            w_bypass;
    logic            w_push;

    // Redirect selection and per-cycle queue/output control decisions
    always_comb begin
        w_redirect = exception | jump | branch_taken;
        w_target   = branch_target;
        if (exception) begin
            w_target = EXC_VECTOR;
        end else if (jump) begin
            w_target = jump_target;
        end
        // Occupancy includes the outstanding response so the queue can never overflow
        w_occ    = r_count + CW'(r_inflight);
        w_req    = !reset && !w_redirect && (w_occ < CW'(FQ_DEPTH));
        // A response arriving in a redirect cycle belongs to the old path
        w_resp   = r_inflight && !w_redirect;
        w_load   = !r_p1_valid || id_ready;
        w_pop    = w_load && (r_count != '0);
        w_bypass = w_load && (r_count == '0) && w_resp;
        w_push   = w_resp && !w_bypass;
    end

    // PC register and the single outstanding memory request
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_inflight <= 1'b0;
            r_req_addr <= '0;
        end else if (w_redirect) begin
            r_pc       <= w_target;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_req;
            if (w_req) begin
                r_req_addr <= r_pc;
                r_pc       <= r_pc + PC_STEP;
            end
        end
    end

    // Prefetch queue storage (contents are don't-care while the entry is empty)
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fq_data[r_tail] <= imem_rdata;
            r_fq_pc[r_tail]   <= r_req_addr;
        end
    end

    // Prefetch queue pointers and occupancy; flushed on redirect
    always_ff @(posedge clk) begin
        if (reset || w_redirect) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // IF/ID output register: queue head first, else bypass the arriving response
    always_ff @(posedge clk) begin
        if (reset) begin
            r_p1_valid  <= 1'b0;
            r_p1_bundle <= '0;
            r_p1_pc     <= '0;
        end else if (w_redirect) begin
            r_p1_valid <= 1'b0;
        end else if (w_pop) begin
            r_p1_valid  <= 1'b1;
            r_p1_bundle <= r_fq_data[r_head];
            r_p1_pc     <= r_fq_pc[r_head];
        end else if (w_bypass) begin
            r_p1_valid  <= 1'b1;
            r_p1_bundle <= imem_rdata;
            r_p1_pc     <= r_req_addr;
        end else if (w_load) begin
            r_p1_valid <= 1'b0;
        end
    end

    assign imem_req  = w_req;
    assign imem_addr = r_pc;
    assign p1_valid  = r_p1_valid;
    assign p1_bundle = r_p1_bundle;
    assign p1_pc     = r_p1_pc;
    assign fq_count  = r_count;

endmodule

// File: tb/tb_vliw_fetch_stage.sv
// tb_vliw_fetch_stage: randomized bench for the fetch stage. The reference
// model tracks the architectural fetch stream (next fetch PC, next PC owed to
// ID) and counts of bundles requested/received/consumed.
module tb_vliw_fetch_stage;

    localparam int              SLOT_W     = 16;
    localparam int              NUM_SLOTS  = 2;
    localparam int              PC_W       = 32;
    localparam int              FQ_DEPTH   = 4;
    localparam int              BW         = NUM_SLOTS * SLOT_W;
    localparam logic [PC_W-1:0] RESET_PC   = 32'h0;
    localparam logic [PC_W-1:0] EXC_VECTOR = 32'h80;
    localparam int              STEP       = BW / 8;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       imem_req;
    logic [PC_W-1:0]            imem_addr;
    logic [BW-1:0]              imem_rdata;
    logic                       branch_taken;
    logic [PC_W-1:0]            branch_target;
    logic                       jump;
    logic [PC_W-1:0]            jump_target;
    logic                       exception;
    logic                       id_ready;
    logic                       p1_valid;
    logic [BW-1:0]              p1_bundle;
    logic [PC_W-1:0]            p1_pc;
    logic [$clog2(FQ_DEPTH):0]  fq_count;

    int errors = 0;
    int checks = 0;

    vliw_fetch_stage #(
        .SLOT_W    (SLOT_W),
        .NUM_SLOTS (NUM_SLOTS),
        .PC_W      (PC_W),
        .FQ_DEPTH  (FQ_DEPTH),
        .RESET_PC  (RESET_PC),
        .EXC_VECTOR(EXC_VECTOR)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .exception    (exception),
        .id_ready     (id_ready),
        .p1_valid     (p1_valid),
        .p1_bundle    (p1_bundle),
        .p1_pc        (p1_pc),
        .fq_count     (fq_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Instruction memory contents as a pure function of the bundle address
    function automatic logic [BW-1:0] memf(input logic [PC_W-1:0] a);
        logic [31:0] h;
        h = (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
        return BW'(h);
    endfunction

    // Reference model state
    logic [PC_W-1:0] m_pc;       // next address to be fetched
    logic [PC_W-1:0] m_dpc;      // next address owed to ID
    logic [PC_W-1:0] m_pend_a;   // address whose data is due this cycle
    bit              m_pend;
    bit              m_infl;
    int              m_recv;     // bundles received from memory not yet consumed by ID

    task automatic model_reset();
        m_pc   = RESET_PC;
        m_dpc  = RESET_PC;
        m_pend = 1'b0;
        m_infl = 1'b0;
        m_recv = 0;
    endtask

    function automatic logic [PC_W-1:0] rand_target();
        logic [PC_W-1:0] t;
        t = PC_W'($urandom) & ~PC_W'(STEP - 1);
        if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF8;
        return t;
    endfunction

    initial begin
        bit              p1v_exp;
        bit              req_exp;
        bit              redir;
        bit              consumed;

        reset         = 1'b1;
        id_ready      = 1'b0;
        branch_taken  = 1'b0;
        jump          = 1'b0;
        exception     = 1'b0;
        branch_target = '0;
        jump_target   = '0;
        imem_rdata    = '0;
        model_reset();
        repeat (2) @(posedge clk);

        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            p1v_exp = (m_recv != 0);
            chk("p1_valid", 64'(p1_valid), 64'(p1v_exp));
            chk("fq_count", 64'(fq_count), 64'(m_recv - int'(p1v_exp)));
            chk("imem_addr", 64'(imem_addr), 64'(m_pc));

            imem_rdata   = m_pend ? memf(m_pend_a) : BW'($urandom);
            reset        = 1'b0;
            branch_taken = 1'b0;
            jump         = 1'b0;
            exception    = 1'b0;
            branch_target = rand_target();
            jump_target   = rand_target();

            if (cyc < 30) begin
                id_ready = 1'b1;
            end else if (cyc < 42) begin
                id_ready = 1'b0;
            end else if (cyc < 60) begin
                id_ready = 1'b1;
            end else if (cyc == 60) begin
                // taken branch with the queue partly filled by a short stall
                id_ready = 1'b0;
            end else if (cyc < 64) begin
                id_ready = 1'b0;
            end else if (cyc == 64) begin
                id_ready      = 1'b1;
                branch_taken  = 1'b1;
                branch_target = 32'h100;
            end else if (cyc < 75) begin
                id_ready = 1'b1;
            end else if (cyc == 75) begin
                id_ready      = 1'b1;
                exception     = 1'b1;
                jump          = 1'b1;
                jump_target   = 32'h200;
                branch_taken  = 1'b1;
                branch_target = 32'h300;
            end else if (cyc < 80) begin
                id_ready = 1'b1;
            end else if (cyc == 80) begin
                id_ready      = 1'b1;
                jump          = 1'b1;
                jump_target   = 32'hFFFF_FFF8;
            end else if (cyc < 90) begin
                id_ready = 1'b1;
            end else if (cyc < 101) begin
                id_ready = 1'b0;
            end else if (cyc == 101) begin
                id_ready = 1'b0;
                reset    = 1'b1;
            end else begin
                id_ready = ($urandom_range(0, 9) < 7);
                reset    = ($urandom_range(0, 199) == 0);
                if ($urandom_range(0, 11) == 0) begin
                    branch_taken = 1'($urandom);
                    jump         = 1'($urandom);
                    exception    = 1'($urandom);
                    if (!(branch_taken || jump || exception)) branch_taken = 1'b1;
                end
            end

            #1;
            redir   = exception || jump || branch_taken;
            req_exp = !reset && !redir &&
                      ((m_recv - int'(p1v_exp) + int'(m_infl)) < FQ_DEPTH);
            chk("imem_req", 64'(imem_req), 64'(req_exp));

            if (reset) begin
                model_reset();
            end else begin
                consumed = p1v_exp && id_ready;
                if (consumed) begin
                    chk("p1_pc", 64'(p1_pc), 64'(m_dpc));
                    chk("p1_bundle", 64'(p1_bundle), 64'(memf(m_dpc)));
                    m_dpc = m_dpc + PC_W'(STEP);
                end
                if (redir) begin
                    m_pc   = exception ? EXC_VECTOR : (jump ? jump_target : branch_target);
                    m_dpc  = m_pc;
                    m_recv = 0;
                    m_infl = 1'b0;
                    m_pend = 1'b0;
                end else begin
                    if (m_infl) m_recv++;
                    if (consumed) m_recv--;
                    m_pend   = req_exp;
                    m_pend_a = m_pc;
                    m_infl   = req_exp;
                    if (req_exp) m_pc = m_pc + PC_W'(STEP);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
